// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed 7-segment scan driver, double-buffered digits, leading-zero blanking, PWM dimming.
// Latency: every output is registered, 1 clock after slot/phase/active-register change; o_Frame flags first slot-0 output.
// Backpressure: none; i_Load is always accepted, the last load before a frame wrap wins.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [4*NUM_DIGITS-1:0]   i_Digits,
  input  logic [NUM_DIGITS-1:0]     i_DP,
  input  logic [NUM_DIGITS-1:0]     i_Enable_Mask,
  input  logic                      i_Blank_Lead,
  input  logic [BRIGHT_WIDTH-1:0]   i_Bright,
  input  logic                      i_Load,
  output logic [6:0]                o_Segments,
  output logic                      o_DP,
  output logic [NUM_DIGITS-1:0]     o_Anodes,
  output logic                      o_Frame
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_cnt;
  logic [SW-1:0]           slot;
  logic [BRIGHT_WIDTH-1:0] phase;
  logic [3:0]              pend_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_vld;
  logic [3:0]              act_dig  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    tick_last;
  logic                    wrap;
  logic                    wrap_q;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_above;
  logic                    lit;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign tick_last = (tick_cnt == TICK_LAST);
  assign wrap      = tick_last && (slot == SLOT_LAST);

  // Slot timer, slot index and free-running PWM phase.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tick_cnt <= '0;
      slot     <= '0;
      phase    <= '0;
    end else begin
      phase <= phase + 1'b1;
      if (tick_last) begin
        tick_cnt <= '0;
        slot     <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Pending/active buffers: active only changes on the frame wrap so a frame is never torn.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        pend_dig[k] <= 4'h0;
        act_dig[k]  <= 4'h0;
      end
      pend_dp  <= '0;
      act_dp   <= '0;
      pend_vld <= 1'b0;
    end else if (wrap && i_Load) begin
      for (int k = 0; k < NUM_DIGITS; k++) act_dig[k] <= i_Digits[4*k +: 4];
      act_dp   <= i_DP;
      pend_vld <= 1'b0;
    end else if (wrap) begin
      if (pend_vld) begin
        for (int k = 0; k < NUM_DIGITS; k++) act_dig[k] <= pend_dig[k];
        act_dp <= pend_dp;
      end
      pend_vld <= 1'b0;
    end else if (i_Load) begin
      for (int k = 0; k < NUM_DIGITS; k++) pend_dig[k] <= i_Digits[4*k +: 4];
      pend_dp  <= i_DP;
      pend_vld <= 1'b1;
    end
  end

  // Leading-zero mask: walk down from the top digit while digits are zero with no DP; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (act_dig[k] == 4'h0) && !act_dp[k];
      blank[k]   = i_Blank_Lead && zero_above && (k != 0);
    end
  end

  assign lit = i_Enable_Mask[slot] && (phase <= i_Bright);

  // Registered drive: one anode at most, everything dark when masked or in the PWM off phase.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_Anodes   <= '1;
      o_Segments <= 7'h7F;
      o_DP       <= 1'b1;
      o_Frame    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q     <= wrap;
      o_Frame    <= wrap_q;
      o_Anodes   <= '1;
      o_Segments <= 7'h7F;
      o_DP       <= 1'b1;
      if (lit) begin
        o_Anodes[slot] <= 1'b0;
        o_Segments     <= blank[slot] ? 7'h7F : hex_to_seg(act_dig[slot]);
        o_DP           <= ~act_dp[slot];
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed scenarios plus random traffic against a frame-level reference model.
// Latency: outputs compared 1 ns after each rising edge against the state of the previous cycle.
// Backpressure: not applicable.
module tb_ssd_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int BW = 2;
  localparam int FRAME = ND * TD;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   i_Digits;
  logic [3:0]    i_DP;
  logic [3:0]    i_Enable_Mask;
  logic          i_Blank_Lead;
  logic [1:0]    i_Bright;
  logic          i_Load;
  logic [6:0]    o_Segments;
  logic          o_DP;
  logic [3:0]    o_Anodes;
  logic          o_Frame;

  int checks = 0;
  int failures = 0;
  int t;

  logic [6:0] seg_tab [16];
  logic [3:0] m_act  [ND];
  logic [3:0] m_pend [ND];
  logic [3:0] m_act_dp;
  logic [3:0] m_pend_dp;
  bit         m_pflag;

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BRIGHT_WIDTH(BW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Digits(i_Digits), .i_DP(i_DP),
    .i_Enable_Mask(i_Enable_Mask), .i_Blank_Lead(i_Blank_Lead), .i_Bright(i_Bright),
    .i_Load(i_Load), .o_Segments(o_Segments), .o_DP(o_DP), .o_Anodes(o_Anodes), .o_Frame(o_Frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < ND; k++) begin
      m_act[k]  = 4'h0;
      m_pend[k] = 4'h0;
    end
    m_act_dp  = 4'h0;
    m_pend_dp = 4'h0;
    m_pflag   = 0;
  endtask

  // One clock: predict the outputs for the current cycle, update the frame buffers, then compare.
  task automatic step();
    int s, ph;
    bit on, bl;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fr;
    s  = (t / TD) % ND;
    ph = t % (1 << BW);
    on = i_Enable_Mask[s] && (ph <= int'(i_Bright));
    bl = 0;
    if (i_Blank_Lead && s != 0) begin
      bl = 1;
      for (int j = s; j < ND; j++) if (m_act[j] != 4'h0 || m_act_dp[j]) bl = 0;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (on) begin
      e_an[s] = 1'b0;
      e_seg   = bl ? 7'h7F : seg_tab[m_act[s]];
      e_dp    = ~m_act_dp[s];
    end
    e_fr = (t >= FRAME) && (t % FRAME == 0);
    if (t % FRAME == FRAME - 1) begin
      if (i_Load) begin
        for (int k = 0; k < ND; k++) m_act[k] = i_Digits[4*k +: 4];
        m_act_dp = i_DP;
      end else if (m_pflag) begin
        for (int k = 0; k < ND; k++) m_act[k] = m_pend[k];
        m_act_dp = m_pend_dp;
      end
      m_pflag = 0;
    end else if (i_Load) begin
      for (int k = 0; k < ND; k++) m_pend[k] = i_Digits[4*k +: 4];
      m_pend_dp = i_DP;
      m_pflag   = 1;
    end
    @(posedge clk); #1;
    t++;
    chk("m_anodes", o_Anodes, e_an);
    chk("m_segments", o_Segments, e_seg);
    chk("m_dp", o_DP, e_dp);
    chk("m_frame", o_Frame, e_fr);
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_anodes"}, o_Anodes, 4'hF);
    chk({tag, "_segments"}, o_Segments, 7'h7F);
    chk({tag, "_dp"}, o_DP, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [6:0] exp_sg [4];
    int lows;
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_sg[0] = 7'b1000000; exp_sg[1] = 7'b1111001; exp_sg[2] = 7'b0001000; exp_sg[3] = 7'b0000000;

    rst = 1'b1; i_Digits = 16'h0; i_DP = 4'h0; i_Enable_Mask = 4'hF;
    i_Blank_Lead = 1'b0; i_Bright = 2'd3; i_Load = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_dark("reset");
    chk("reset_frame", o_Frame, 1'b0);
    rst = 1'b0;

    // Scan order after the first wrap.
    i_Digits = 16'h8A10; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    run_to(16);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("scan_anodes", o_Anodes, exp_an[k / 4]);
      chk("scan_segments", o_Segments, exp_sg[k / 4]);
      chk("scan_frame", o_Frame, (k == 0));
    end

    // Tear-free load issued during slot 1.
    run_to(37);
    i_Digits = 16'h1234; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    run_to(41); chk("tear_s2_seg", o_Segments, 7'b0001000); chk("tear_s2_an", o_Anodes, 4'b1011);
    run_to(45); chk("tear_s3_seg", o_Segments, 7'b0000000); chk("tear_s3_an", o_Anodes, 4'b0111);
    run_to(48); chk("tear_pre_frame", o_Frame, 1'b0);
    run_to(49); chk("tear_frame", o_Frame, 1'b1); chk("tear_s0_seg", o_Segments, 7'b0011001);

    // Load coinciding with the wrap goes straight to the active buffer.
    run_to(63);
    i_Digits = 16'h00F0; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    run_to(65); chk("coll_s0_seg", o_Segments, 7'b1000000); chk("coll_frame", o_Frame, 1'b1);
    run_to(69); chk("coll_s1_seg", o_Segments, 7'b0001110); chk("coll_s1_an", o_Anodes, 4'b1101);

    // Leading-zero suppression, then a DP stops suppression at digit 2.
    run_to(70);
    i_Blank_Lead = 1'b1; i_Digits = 16'h0005; i_DP = 4'h0; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    run_to(81); chk("sup_s0_seg", o_Segments, 7'b0010010);
    run_to(85); chk("sup_s1_seg", o_Segments, 7'h7F); chk("sup_s1_an", o_Anodes, 4'b1101);
    run_to(89); chk("sup_s2_seg", o_Segments, 7'h7F); chk("sup_s2_an", o_Anodes, 4'b1011);
    run_to(93); chk("sup_s3_seg", o_Segments, 7'h7F); chk("sup_s3_an", o_Anodes, 4'b0111);
    run_to(96);
    i_DP = 4'b0100; i_Load = 1'b1;
    step();
    i_Load = 1'b0; i_DP = 4'h0;
    run_to(117); chk("dp_s1_seg", o_Segments, 7'b1000000);
    run_to(121); chk("dp_s2_seg", o_Segments, 7'b1000000); chk("dp_s2_dp", o_DP, 1'b0);
    run_to(125); chk("dp_s3_seg", o_Segments, 7'h7F); chk("dp_s3_dp", o_DP, 1'b1);

    // Minimum brightness: anode low one clock in four.
    run_to(128);
    i_Bright = 2'd0;
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (o_Anodes != 4'hF) lows++;
    end
    chk("pwm_low_count", lows, 4);

    // Masked digit 2 stays dark for its whole slot.
    i_Bright = 2'd3; i_Enable_Mask = 4'b1011;
    run_to(149); chk("mask_s1_an", o_Anodes, 4'b1101);
    run_to(152);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_dark("mask_s2");
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      i_Load        = ($urandom_range(3) == 0);
      i_Digits      = 16'($urandom);
      i_DP          = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(1) == 0) i_Digits[15:8] = 8'h00;
      i_Enable_Mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      i_Blank_Lead  = 1'($urandom);
      i_Bright      = 2'($urandom);
      step();
    end

    // Reset mid-frame during slot 2 with a load pending.
    i_Load = 1'b0; i_Enable_Mask = 4'hF; i_Bright = 2'd3; i_Blank_Lead = 1'b0; i_DP = 4'h0;
    while (t % FRAME != 8) step();
    i_Digits = 16'h9999; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    step();
    chk("prerst_an", o_Anodes, 4'b1011);
    #3;
    rst = 1'b1;
    #1;
    chk_dark("rst_async");
    chk("rst_async_frame", o_Frame, 1'b0);
    @(posedge clk); #1;
    chk_dark("rst_hold");
    rst = 1'b0;
    model_reset();
    run_to(1);
    chk("post_s0_seg", o_Segments, 7'b1000000); chk("post_s0_an", o_Anodes, 4'b1110);
    run_to(16); chk("post_pre_frame", o_Frame, 1'b0);
    run_to(17); chk("post_frame", o_Frame, 1'b1); chk("post_lost_seg", o_Segments, 7'b1000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named i_CLK and i_RST.
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the number of scanned digits, legal range 1..8.
REQ-003 Parameter TICK_DIV, default 100000, SHALL set the clocks per digit slot, legal range >= 2.
REQ-004 Parameter BRIGHT_WIDTH, default 4, SHALL set the width of the PWM brightness control.
REQ-005 The ports SHALL be as follows:
- i_CLK  in  1  clock
- i_RST  in  1  asynchronous active-high reset
- i_Digits  in  4*NUM_DIGITS  hex nibbles; digit k is at [4k+3:4k]; digit 0 is rightmost
- i_DP  in  NUM_DIGITS  decimal point request per digit, active-high
- i_Enable_Mask  in  NUM_DIGITS  per-digit enable; 0 forces that digit dark
- i_Blank_Lead  in  1  leading-zero suppression enable
- i_Bright  in  BRIGHT_WIDTH  brightness code
- i_Load  in  1  one-cycle strobe that captures i_Digits and i_DP
- o_Segments  out  7  active-low, bit order {g,f,e,d,c,b,a}
- o_DP  out  1  active-low decimal point
- o_Anodes  out  NUM_DIGITS  active-low; bit k drives digit k
- o_Frame  out  1  one-cycle pulse on each scan wrap

Function
REQ-006 Tick counter: SHALL count 0..TICK_DIV-1 and wrap to 0; the slot index SHALL advance only on the cycle the counter equals TICK_DIV-1.
REQ-007 Slot index: SHALL count 0..NUM_DIGITS-1 and wrap to 0; slot s SHALL display digit s.
REQ-008 Buffering: the block SHALL hold a pending register and an active register, each storing digits and DP bits. i_Load SHALL write the pending register and set a pending flag. When several loads occur before a wrap, the last one wins.
REQ-009 Wrap cycle: on the cycle the slot goes from NUM_DIGITS-1 to 0, the block SHALL copy pending to active (if the pending flag is set) and clear the flag. Display updates SHALL never occur mid-frame.
REQ-010 If i_Load and a wrap occur in the same cycle, the i_Load data SHALL go directly to the active register, and the pending flag SHALL be cleared.
REQ-011 o_Frame SHALL be 1 for exactly the one cycle following the wrap cycle. It SHALL be registered and aligned with the first output cycle of slot 0.
REQ-012 Decode: the block SHALL use standard hex 0-F, active-low {g..a}. Required values: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-013 Leading-zero suppression: when i_Blank_Lead=1, each digit k SHALL be blanked (segments 1111111) if every active digit j>=k is 0 and its active DP bit is 0. Digit 0 SHALL never be suppressed. The suppression mask SHALL be computed from the active register only.
REQ-014 o_DP SHALL equal the inverse of the active DP bit of the current slot. o_DP SHALL be unaffected by suppression but SHALL be subject to the enable mask and PWM.
REQ-015 PWM: a free-running BRIGHT_WIDTH-bit phase counter SHALL increment every clock. The current anode SHALL be driven only while phase <= i_Bright, giving a duty of (i_Bright+1)/2^BRIGHT_WIDTH. An all-ones code SHALL mean full on.
REQ-016 Dark conditions: the anode of the current slot SHALL be 0 only if i_Enable_Mask[s]=1 and the PWM is on. Otherwise all anodes SHALL be 1, and o_Segments and o_DP SHALL be all 1.
REQ-017 At most one o_Anodes bit SHALL ever be 0.
REQ-018 All outputs SHALL be registered, with a latency of 1 clock from the slot, PWM or active-register change.
REQ-019 i_Enable_Mask, i_Blank_Lead and i_Bright SHALL take effect on the next clock. They SHALL NOT be buffered.

Reset
REQ-020 While i_RST=1, the block SHALL hold the tick, slot and phase counters, the pending and active registers, and the pending flag at 0.
REQ-021 While i_RST=1, the block SHALL drive o_Anodes all 1, o_Segments=1111111, o_DP=1 and o_Frame=0.
REQ-022 Reset asserted mid-frame SHALL immediately darken the display and discard any pending load. After release, scanning SHALL restart at slot 0 with tick 0.
REQ-023 The first o_Frame pulse after reset SHALL occur NUM_DIGITS*TICK_DIV+1 clocks after the first active edge.

Verification (NUM_DIGITS=4, TICK_DIV=4, BRIGHT_WIDTH=2 unless noted)
REQ-024 Scan order:
- Stimulus: load digits 3,2,1,0 = 8,A,1,0; i_Bright=3; mask=1111.
- Response: after the next wrap, o_Anodes cycles 1110,1101,1011,0111, each held 4 clocks.
- Response: segments are 1000000, 1111001, 0001000, 0000000.
REQ-025 Tear-free load:
- Stimulus: i_Load of 1234h issued during slot 1.
- Response: the slot 2 and slot 3 outputs still show the old value.
- Response: the new value appears at slot 0, with o_Frame high on that cycle.
REQ-026 Load/wrap collision:
- Stimulus: i_Load of 00F0h on the wrap cycle.
- Response: slot 0 of the immediately following frame shows 0 (segments 1000000).
- Response: slot 1 shows F.
REQ-027 Suppression:
- Stimulus: digits 0005h, i_Blank_Lead=1, no DP.
- Response: slots 3, 2 and 1 show 1111111 with their anodes driven; slot 0 shows 5 (0010010).
- Stimulus: set i_DP[2].
- Response: slot 2 shows 0 with o_DP=0.
REQ-028 PWM and mask:
- Stimulus: i_Bright=0.
- Response: the anode is low exactly 1 clock in every 4.
- Stimulus: i_Enable_Mask=1011.
- Response: slot 2 stays all-1 for its full slot time.
REQ-029 Reset mid-frame:
- Stimulus: assert i_RST asynchronously during slot 2 with a pending load.
- Response: outputs go dark within the same cycle.
- Response: after release, slot 0 shows 0 (the pending data is lost).
- Response: the first o_Frame pulse occurs at clock 17.
